lut_cfg_loader: RTL and testbench
=================================

// Module: lut_cfg_loader
// PURPOSE
//  Configuration writer for the CLB LUT array: accepts a serial bitstream, assembles one
//  16-bit truth table per LUT, and commits all tables atomically onto the LUT config buses.
//  Drives prgm_b / CLB_prgm_b so that LUTs evaluate only when a complete image is committed.
//  Sits between the host/bitstream port and the CLB array.
// PARAMETERS
//  NUM_LUTS   4    number of 4-input LUTs configured per image
//  LUT_BITS   16   truth-table width per LUT (entry i selected by {x4,x3,x2,x1}==i)
// PORTS
//  clk         in   1                    system clock, all logic on rising edge
//  rst         in   1                    synchronous, active-high reset
//  start       in   1                    pulse: begin loading a new image (ignored unless IDLE/DONE)
//  abort       in   1                    pulse: discard partial image, return to IDLE
//  cfg_bit     in   1                    serial config data
//  cfg_valid   in   1                    cfg_bit valid this cycle
//  cfg_ready   out  1                    loader accepts cfg_bit this cycle
//  lut_cfg     out  NUM_LUTS*LUT_BITS    committed tables; LUT k uses [k*16 +: 16]
//  prgm_b      out  1                    1 = a valid image has been committed since reset
//  CLB_prgm_b  out  1                    1 = CLBs in programming mode (LUT outputs not valid)
//  busy        out  1                    high in LOAD
//  done        out  1                    one-cycle pulse on commit
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, lut_cfg=0, shadow reg=0, bit count=0, prgm_b=0,
//   CLB_prgm_b=1, cfg_ready=0, busy=0, done=0. Reset mid-LOAD discards the partial image.
//  States: IDLE, LOAD, COMMIT, RUN.
//  IDLE: cfg_ready=0. start=1 -> LOAD, bit count cleared, CLB_prgm_b=1.
//  LOAD: cfg_ready=1, busy=1. A bit is accepted when cfg_valid & cfg_ready. Accepted bit n
//   (n = 0..NUM_LUTS*LUT_BITS-1) is written to shadow[n]: LUT0 entry0 first, LSB-first.
//   Count width = clog2(NUM_LUTS*LUT_BITS). No acceptance without cfg_valid; gaps are allowed.
//   When the last bit (n = NUM_LUTS*LUT_BITS-1) is accepted -> COMMIT next cycle.
//   abort=1 in LOAD -> IDLE next cycle; shadow discarded; lut_cfg and prgm_b unchanged;
//   CLB_prgm_b returns to 0 iff prgm_b=1, else stays 1. abort has priority over a same-cycle bit.
//   start during LOAD is ignored.
//  COMMIT (one cycle): cfg_ready=0. lut_cfg <= shadow, prgm_b <= 1, done=1 for this cycle.
//   Next state RUN. CLB_prgm_b <= 0 one cycle after lut_cfg updates (in RUN), so
//   the CLBs never evaluate a stale or partial table.
//  RUN: CLB_prgm_b=0, cfg_ready=0, lut_cfg held. start=1 -> LOAD, CLB_prgm_b=1 in the
//   same registered update; lut_cfg keeps the old image until the next COMMIT.
//   abort in IDLE/RUN: no effect.
//  Latency: last accepted bit at cycle T -> lut_cfg/prgm_b/done valid at T+1 (COMMIT
//   registered at T+1 edge-out), CLB_prgm_b=0 at T+2.
//  All outputs registered; no combinational path from inputs to outputs except none (cfg_ready
//   is a function of state only).
// TESTING
//  1. Reset then start, feed 64 bits forming LUT0=16'hA5A5, LUT1=16'h0001, LUT2=16'h8000,
//     LUT3=16'hFFFF -> done pulse once; lut_cfg=64'hFFFF_8000_0001_A5A5; prgm_b=1;
//     CLB_prgm_b falls exactly one cycle after done.
//  2. Same image with cfg_valid toggling every other cycle -> identical lut_cfg; 64 bits
//     accepted over 128 cycles; no bit accepted while cfg_valid=0.
//  3. After test 1, start, load 20 bits, abort -> IDLE, lut_cfg still 64'hFFFF_8000_0001_A5A5,
//     prgm_b=1, CLB_prgm_b=0; done never pulses.
//  4. Assert rst after 40 bits -> all outputs at reset values next cycle; a fresh 64-bit load
//     of all-0x5555 then commits 64'h5555_5555_5555_5555 with no residue.
//  5. start during LOAD and abort with cfg_valid on same cycle -> start ignored; aborted bit not
//     stored (verified by reload: bit count restarts at 0).
//  6. Reload in RUN: start -> CLB_prgm_b=1 next cycle, lut_cfg unchanged until new COMMIT.

Source files
------------

// File: rtl/lut_cfg_loader_if.sv
// Serial configuration stream between the bitstream host and the LUT loader.
interface lut_cfg_loader_if;
  logic cfg_bit;
  logic cfg_valid;
  logic cfg_ready;

  modport master (output cfg_bit, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_bit, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/lut_cfg_loader.sv
// Assembles a serial bitstream into NUM_LUTS truth tables and commits them atomically,
// holding the CLBs in programming mode until a complete image is live.
module lut_cfg_loader #(
  parameter int unsigned NUM_LUTS = 4,
  parameter int unsigned LUT_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         abort_i,
  lut_cfg_loader_if.slave              cfg_if,
  output logic [NUM_LUTS*LUT_BITS-1:0] lut_cfg_o,
  output logic                         prgm_b_o,
  output logic                         clb_prgm_b_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int unsigned TOTAL = NUM_LUTS * LUT_BITS;
  localparam int unsigned CNT_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOTAL-1:0]   shadow_q, shadow_d;
  logic [TOTAL-1:0]   lut_q, lut_d;
  logic               prgm_q, prgm_d;
  logic               clb_q, clb_d;
  logic               done_q, done_d;
  logic               ready_q, busy_q;

  // State and output registers; ready/busy are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      lut_q    <= '0;
      prgm_q   <= 1'b0;
      clb_q    <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      lut_q    <= lut_d;
      prgm_q   <= prgm_d;
      clb_q    <= clb_d;
      done_q   <= done_d;
      ready_q  <= (state_d == LOAD);
      busy_q   <= (state_d == LOAD);
    end
  end

  // The last accepted bit commits in the same update so lut_cfg/done appear in COMMIT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    lut_d    = lut_q;
    prgm_d   = prgm_q;
    clb_d    = clb_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (start_i) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
          clb_d    = 1'b1;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d  = IDLE;
          cnt_d    = '0;
          shadow_d = '0;
          clb_d    = ~prgm_q;
        end else if (cfg_if.cfg_valid) begin
          shadow_d[cnt_q] = cfg_if.cfg_bit;
          cnt_d           = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = COMMIT;
            lut_d   = shadow_d;
            prgm_d  = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = RUN;
        clb_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_if.cfg_ready = ready_q;
  assign lut_cfg_o        = lut_q;
  assign prgm_b_o         = prgm_q;
  assign clb_prgm_b_o     = clb_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Scenario bench for lut_cfg_loader against an image-level reference model.
module tb_lut_cfg_loader;
  localparam logic [63:0] IMG1 = 64'hFFFF_8000_0001_A5A5;
  localparam logic [63:0] IMG5 = 64'h5555_5555_5555_5555;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [63:0] lut_cfg;
  logic        prgm_b, clb_prgm_b, busy, done;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int accept_cnt   = 0;

  // Reference model: last committed image and whether any image was committed.
  logic [63:0] model_img;
  logic        model_prgm;

  lut_cfg_loader_if cfg_if ();

  lut_cfg_loader #(.NUM_LUTS(4), .LUT_BITS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .abort_i      (abort),
    .cfg_if       (cfg_if),
    .lut_cfg_o    (lut_cfg),
    .prgm_b_o     (prgm_b),
    .clb_prgm_b_o (clb_prgm_b),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    if (cfg_if.cfg_valid && cfg_if.cfg_ready) accept_cnt++;
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Feeds bits [lo, hi] of img; gap_pct is the chance of an idle (garbage-bit) cycle first.
  task automatic feed_bits(input logic [63:0] img, input int lo, input int hi, input int gap_pct);
    for (int i = lo; i <= hi; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_bit   = ~img[i];
        step();
      end
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_bit   = img[i];
      step();
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_if.cfg_bit = 1'b0; cfg_if.cfg_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    tests_run++;
    if (lut_cfg !== 64'h0) begin
      tests_failed++; $display("FAIL reset_lut: got %h expected %h", lut_cfg, 64'h0);
    end
    tests_run++;
    if ({prgm_b, clb_prgm_b, cfg_if.cfg_ready, busy, done} !== 5'b01000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected %b", {prgm_b, clb_prgm_b, cfg_if.cfg_ready, busy, done}, 5'b01000);
    end
    model_img = '0; model_prgm = 1'b0;
  endtask

  task automatic test_basic_load();
    int d0;
    pulse_start();
    tests_run++;
    if ({clb_prgm_b, cfg_if.cfg_ready, busy} !== 3'b111) begin
      tests_failed++; $display("FAIL load_entry: got %b expected %b", {clb_prgm_b, cfg_if.cfg_ready, busy}, 3'b111);
    end
    d0 = done_cnt;
    feed_bits(IMG1, 0, 63, 0);
    tests_run++;
    if ({done, prgm_b, clb_prgm_b, cfg_if.cfg_ready} !== 4'b1110 || lut_cfg !== IMG1) begin
      tests_failed++;
      $display("FAIL commit_cycle: got flags %b lut %h expected flags 1110 lut %h", {done, prgm_b, clb_prgm_b, cfg_if.cfg_ready}, lut_cfg, IMG1);
    end
    step();
    tests_run++;
    if ({done, clb_prgm_b, busy} !== 3'b000) begin
      tests_failed++; $display("FAIL run_entry: got %b expected %b", {done, clb_prgm_b, busy}, 3'b000);
    end
    step();
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      tests_failed++; $display("FAIL done_once: got %0d expected 1", done_cnt - d0);
    end
    model_img = IMG1; model_prgm = 1'b1;
  endtask

  task automatic test_gapped_load();
    int a0, cycles;
    pulse_start();
    a0 = accept_cnt;
    cycles = 0;
    for (int i = 0; i < 64; i++) begin
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_bit = ~IMG1[i]; step(); cycles++;
      cfg_if.cfg_valid = 1'b1; cfg_if.cfg_bit = IMG1[i];  step(); cycles++;
    end
    cfg_if.cfg_valid = 1'b0;
    tests_run++;
    if (accept_cnt - a0 !== 64 || cycles !== 128) begin
      tests_failed++; $display("FAIL gap_accepts: got %0d in %0d cycles expected 64 in 128", accept_cnt - a0, cycles);
    end
    tests_run++;
    if (done !== 1'b1 || lut_cfg !== IMG1) begin
      tests_failed++; $display("FAIL gap_image: got done %b lut %h expected done 1 lut %h", done, lut_cfg, IMG1);
    end
    step(); step();
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    pulse_start();
    feed_bits(~IMG1, 0, 19, 0);
    abort = 1'b1; step(); abort = 1'b0;
    step();
    tests_run++;
    if (lut_cfg !== IMG1 || {prgm_b, clb_prgm_b, cfg_if.cfg_ready, busy} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL abort_hold: got lut %h flags %b expected lut %h flags 1000", lut_cfg, {prgm_b, clb_prgm_b, cfg_if.cfg_ready, busy}, IMG1);
    end
    tests_run++;
    if (done_cnt !== d0) begin
      tests_failed++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0);
    end
    abort = 1'b1; step(); abort = 1'b0;
    tests_run++;
    if (lut_cfg !== IMG1 || clb_prgm_b !== 1'b0) begin
      tests_failed++; $display("FAIL abort_idle_noeffect: got lut %h clb %b expected lut %h clb 0", lut_cfg, clb_prgm_b, IMG1);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    feed_bits(~IMG5, 0, 39, 10);
    rst = 1'b1; step(); rst = 1'b0;
    tests_run++;
    if (lut_cfg !== 64'h0 || {prgm_b, clb_prgm_b, cfg_if.cfg_ready, busy, done} !== 5'b01000) begin
      tests_failed++;
      $display("FAIL midload_reset: got lut %h flags %b expected lut 0 flags 01000", lut_cfg, {prgm_b, clb_prgm_b, cfg_if.cfg_ready, busy, done});
    end
    pulse_start();
    feed_bits(IMG5, 0, 63, 0);
    tests_run++;
    if (lut_cfg !== IMG5 || done !== 1'b1) begin
      tests_failed++; $display("FAIL fresh_load: got lut %h done %b expected lut %h done 1", lut_cfg, done, IMG5);
    end
    step(); step();
  endtask

  task automatic test_start_abort_same_cycle();
    logic [63:0] img_b;
    img_b = {$urandom, $urandom};
    pulse_start();
    feed_bits(~img_b, 0, 9, 0);
    start = 1'b1; abort = 1'b1; cfg_if.cfg_valid = 1'b1; cfg_if.cfg_bit = 1'b1;
    step();
    start = 1'b0; abort = 1'b0; cfg_if.cfg_valid = 1'b0;
    tests_run++;
    if ({cfg_if.cfg_ready, busy, clb_prgm_b} !== 3'b000 || lut_cfg !== IMG5) begin
      tests_failed++;
      $display("FAIL start_abort_idle: got flags %b lut %h expected flags 000 lut %h", {cfg_if.cfg_ready, busy, clb_prgm_b}, lut_cfg, IMG5);
    end
    pulse_start();
    feed_bits(img_b, 0, 29, 0);
    start = 1'b1;
    feed_bits(img_b, 30, 30, 0);
    start = 1'b0;
    feed_bits(img_b, 31, 63, 0);
    tests_run++;
    if (lut_cfg !== img_b || done !== 1'b1) begin
      tests_failed++; $display("FAIL reload_count: got lut %h done %b expected lut %h done 1", lut_cfg, done, img_b);
    end
    step(); step();
    model_img = img_b; model_prgm = 1'b1;
  endtask

  task automatic test_reload_in_run();
    logic [63:0] img_c;
    img_c = {$urandom, $urandom};
    pulse_start();
    tests_run++;
    if (clb_prgm_b !== 1'b1 || lut_cfg !== model_img) begin
      tests_failed++; $display("FAIL run_restart: got clb %b lut %h expected clb 1 lut %h", clb_prgm_b, lut_cfg, model_img);
    end
    feed_bits(img_c, 0, 62, 25);
    tests_run++;
    if (lut_cfg !== model_img || done !== 1'b0) begin
      tests_failed++; $display("FAIL run_hold_old: got lut %h done %b expected lut %h done 0", lut_cfg, done, model_img);
    end
    feed_bits(img_c, 63, 63, 0);
    tests_run++;
    if (lut_cfg !== img_c || clb_prgm_b !== 1'b1) begin
      tests_failed++; $display("FAIL run_new_commit: got lut %h clb %b expected lut %h clb 1", lut_cfg, clb_prgm_b, img_c);
    end
    step();
    tests_run++;
    if (clb_prgm_b !== 1'b0) begin
      tests_failed++; $display("FAIL run_clb_fall: got %b expected 0", clb_prgm_b);
    end
    model_img = img_c; model_prgm = 1'b1;
  endtask

  task automatic test_random();
    logic [63:0] img;
    int cut;
    rst = 1'b1; step(); rst = 1'b0;
    model_img = '0; model_prgm = 1'b0;
    for (int it = 0; it < 12; it++) begin
      img = {$urandom, $urandom};
      pulse_start();
      if ($urandom_range(2) == 0) begin
        cut = int'($urandom_range(62));
        feed_bits(img, 0, cut, 30);
        abort = 1'b1; cfg_if.cfg_valid = 1'(($urandom_range(1)));
        step();
        abort = 1'b0; cfg_if.cfg_valid = 1'b0;
        tests_run++;
        if (lut_cfg !== model_img || prgm_b !== model_prgm || clb_prgm_b !== !model_prgm || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_abort[%0d]: got lut %h prgm %b clb %b busy %b expected lut %h prgm %b clb %b busy 0",
                   it, lut_cfg, prgm_b, clb_prgm_b, busy, model_img, model_prgm, !model_prgm);
        end
      end else begin
        feed_bits(img, 0, 63, 30);
        model_img = img; model_prgm = 1'b1;
        step();
        tests_run++;
        if (lut_cfg !== model_img || prgm_b !== 1'b1 || clb_prgm_b !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_commit[%0d]: got lut %h prgm %b clb %b expected lut %h prgm 1 clb 0",
                   it, lut_cfg, prgm_b, clb_prgm_b, model_img);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_abort();
    test_reset_mid_load();
    test_start_abort_same_cycle();
    test_reload_in_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
